// File: rtl/tick_delay_arbiter_if.sv
// Requester-side bundle for the shared tick delay timer.
// The master side belongs to the requesters; the slave side belongs to the arbiter.
interface tick_delay_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;

    modport master (
        output req,
        output len,
        input  grant,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        input  len,
        output grant,
        output done,
        output busy
    );
endinterface

// File: rtl/tick_delay_arbiter.sv
// Shared delay timer: round-robin grant of a single prescaler/counter pair to NREQ requesters,
// with a one-cycle done pulse once the owner's programmed number of ticks has elapsed.
module tick_delay_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned LW       = 16,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    tick_delay_arbiter_if.slave  bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] LastIdx  = IW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [LW-1:0]   rem_q, rem_d;

    logic [IW-1:0]   pick_lo, pick_hi, pick;
    logic            hi_found;
    logic [LW-1:0]   len_sel;
    logic            owner_req;
    logic [IW-1:0]   next_ptr;

    // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
    always_comb begin
        pick_lo  = '0;
        pick_hi  = '0;
        hi_found = 1'b0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                pick_lo = IW'(i);
                if (IW'(i) >= ptr_q) begin
                    pick_hi  = IW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick = hi_found ? pick_hi : pick_lo;
    end

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (owner_q == IW'(i)) begin
                len_sel = bus.len[i*LW +: LW];
            end
        end
    end

    assign owner_req = bus.req[owner_q];
    assign next_ptr  = (owner_q == LastIdx) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    owner_d = pick;
                    grant_d = NREQ'(1) << pick;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                rem_d   = len_sel;
                presc_d = '0;
                if (!owner_req) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = StIdle;
                end else if (len_sel == '0) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!owner_req) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = StIdle;
                end else if (presc_q == PresLast) begin
                    presc_d = '0;
                    if (rem_q != '0) begin
                        rem_d = rem_q - LW'(1);
                    end
                    if (rem_q == LW'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            StDone: begin
                grant_d = '0;
                ptr_d   = next_ptr;
                state_d = StIdle;
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            presc_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
        end
    end

    // A reset landing on the DONE cycle swallows the pulse.
    assign bus.grant = grant_q;
    assign bus.done  = ((state_q == StDone) && !rst) ? grant_q : '0;
    assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_tick_delay_arbiter.sv
// Scoreboard bench for tick_delay_arbiter: directed stimulus pushes expected grant/done events,
// a negedge monitor pops and compares them whenever the DUT raises a grant or a done pulse.
module tb_tick_delay_arbiter;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned LW       = 16;
    localparam int unsigned PRESCALE = 4;

    logic clk = 1'b0;
    logic rst;

    tick_delay_arbiter_if #(.NREQ(NREQ), .LW(LW)) bus ();

    tick_delay_arbiter #(
        .NREQ    (NREQ),
        .LW      (LW),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; sampled on negedges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NREQ-1:0] vec;
        int              at;
    } exp_t;

    exp_t exp_grant[$];
    exp_t exp_done[$];
    int   ntests = 0;
    int   nfail  = 0;
    logic [NREQ-1:0] prev_grant = '0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] expv);
        ntests++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic void push_g(input logic [NREQ-1:0] v, input int at);
        exp_t e;
        e.vec = v;
        e.at  = at;
        exp_grant.push_back(e);
    endfunction

    function automatic void push_d(input logic [NREQ-1:0] v, input int at);
        exp_t e;
        e.vec = v;
        e.at  = at;
        exp_done.push_back(e);
    endfunction

    task automatic set_len(input int i, input logic [LW-1:0] v);
        bus.len[i*LW +: LW] = v;
    endtask

    task automatic go(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.done !== '0) begin
            if (exp_done.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = exp_done.pop_front();
                check("done_vec", 32'(bus.done), 32'(e.vec));
                check("done_edge", 32'(cyc), 32'(e.at));
            end
        end
        if (bus.grant !== '0 && prev_grant === '0) begin
            if (exp_grant.size() == 0) begin
                check("unexpected_grant", 32'(bus.grant), 32'd0);
            end else begin
                e = exp_grant.pop_front();
                check("grant_vec", 32'(bus.grant), 32'(e.vec));
                check("grant_edge", 32'(cyc), 32'(e.at));
            end
        end
        prev_grant = bus.grant;
    end

    initial begin
        rst     = 1'b1;
        bus.req = '1;
        bus.len = '0;

        // Reset held for three edges with every request high.
        for (int k = 1; k <= 3; k++) begin
            go(k);
            check("rst_grant", 32'(bus.grant), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
        end
        rst     = 1'b0;
        bus.req = 4'b0001;
        set_len(0, 16'd3);
        push_g(4'b0001, 4);
        push_d(4'b0001, 17);

        go(17);
        check("busy_in_done", 32'(bus.busy), 32'd1);
        bus.req = '0;
        go(18);
        check("busy_after_done", 32'(bus.busy), 32'd0);

        // Zero length: LOAD goes straight to DONE.
        go(19);
        bus.req = 4'b0100;
        set_len(2, 16'd0);
        push_g(4'b0100, 20);
        push_d(4'b0100, 21);
        go(21);
        bus.req = '0;

        // Pointer back to 0, then round robin with all requests held.
        go(22);
        rst = 1'b1;
        go(23);
        rst     = 1'b0;
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) set_len(i, 16'd1);
        push_g(4'b0001, 24); push_d(4'b0001, 29);
        push_g(4'b0010, 31); push_d(4'b0010, 36);
        push_g(4'b0100, 38); push_d(4'b0100, 43);
        push_g(4'b1000, 45); push_d(4'b1000, 50);
        go(50);
        bus.req = 4'b0101;
        push_g(4'b0001, 52); push_d(4'b0001, 57);
        push_g(4'b0100, 59); push_d(4'b0100, 64);
        go(64);
        bus.req = '0;

        // Abort: owner 1 drops req in its third RUN cycle.
        go(65);
        bus.req = 4'b0010;
        set_len(1, 16'd5);
        push_g(4'b0010, 66);
        go(69);
        bus.req = 4'b0001;
        go(70);
        check("abort_grant", 32'(bus.grant), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        bus.req = 4'b0011;
        set_len(0, 16'd0);
        push_g(4'b0001, 71);
        push_d(4'b0001, 72);
        go(72);
        bus.req = '0;

        // Reset while RUN with remaining == 2.
        go(73);
        bus.req = 4'b0100;
        set_len(2, 16'd3);
        push_g(4'b0100, 74);
        go(79);
        rst = 1'b1;
        go(80);
        check("midrun_rst_grant", 32'(bus.grant), 32'd0);
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        check("midrun_rst_done", 32'(bus.done), 32'd0);
        rst     = 1'b0;
        bus.req = 4'b1000;
        set_len(3, 16'd1);
        push_g(4'b1000, 81);
        push_d(4'b1000, 86);
        go(86);
        bus.req = '0;

        go(92);
        check("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
        check("done_queue_drained", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
